// File: rtl/fixed_point_requantizer.sv
// ============================================================================
// fixed_point_requantizer
//
// Purpose
//   Narrows LANES parallel fixed-point samples from WIDTH_IN to WIDTH_OUT
//   bits. Each lane is divided by 2^D (D = WIDTH_IN - WIDTH_OUT), rounded
//   according to the per-beat rounding mode, and then saturated to the
//   output range. All lanes share one valid/ready handshake. The datapath is
//   a two-stage pipeline with full-throughput backpressure.
//
//   Stage 1 registers the truncated (floor) value of each lane and a one-bit
//   "round up" decision. Stage 2 registers the incremented value after
//   saturation, along with the per-lane saturation flags.
//
// Parameters
//   WIDTH_IN   input sample width per lane
//   WIDTH_OUT  output sample width per lane (must not exceed WIDTH_IN)
//   LANES      number of lanes sharing the handshake
//   IS_SIGNED  1 = two's-complement samples, 0 = unsigned samples
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   s_valid    input beat valid
//   s_ready    block can accept an input beat
//   s_data     input lanes; lane k occupies [k*WIDTH_IN +: WIDTH_IN]
//   s_mode     rounding mode, captured with the beat:
//                0 floor, 1 half-up (+inf), 2 half-to-even,
//                3 half-away-from-zero
//   m_valid    output beat valid
//   m_ready    downstream accepts the output beat
//   m_data     output lanes; lane k occupies [k*WIDTH_OUT +: WIDTH_OUT]
//   m_sat      per-lane flag, set when that lane was clamped
//   sat_clr    synchronous clear of sat_count (wins over an increment)
//   sat_count  number of output transfers with any m_sat bit set,
//              saturating at 16'hFFFF
// ============================================================================
module fixed_point_requantizer #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_OUT = 8,
    parameter int LANES     = 4,
    parameter int IS_SIGNED = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [LANES*WIDTH_IN-1:0]    s_data,
    input  logic [1:0]                   s_mode,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [LANES*WIDTH_OUT-1:0]   m_data,
    output logic [LANES-1:0]             m_sat,
    input  logic                         sat_clr,
    output logic [15:0]                  sat_count
);

    localparam int D   = WIDTH_IN - WIDTH_OUT;
    localparam int WX  = WIDTH_OUT + 2;     // stage-2 width, absorbs the +1 carry
    localparam bit SGN = (IS_SIGNED != 0);

    generate
        if (WIDTH_IN < 1 || WIDTH_OUT < 1 || LANES < 1 || WIDTH_OUT > WIDTH_IN) begin : g_bad_params
            $error("fixed_point_requantizer: illegal parameters WIDTH_IN=%0d WIDTH_OUT=%0d LANES=%0d",
                   WIDTH_IN, WIDTH_OUT, LANES);
        end
    endgenerate

    typedef enum logic [1:0] {
        RND_FLOOR     = 2'd0,
        RND_HALF_UP   = 2'd1,
        RND_HALF_EVEN = 2'd2,
        RND_HALF_AWAY = 2'd3
    } round_mode_t;

    // ------------------------------------------------------------------
    // Handshake / pipeline control
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s1_load;      // stage 1 may take a new (possibly empty) beat
    logic s2_load;      // stage 2 may take a new (possibly empty) beat

    assign s2_load = !m_valid || m_ready;
    assign s1_load = !s1_valid || s2_load;
    // Reset is folded in so that s_ready is low for the whole reset
    // interval, even before any clock edge has occurred.
    assign s_ready = !rst && s1_load;

    // ------------------------------------------------------------------
    // Stage 1 combinational: floor value and round-up decision per lane
    // ------------------------------------------------------------------
    logic [WIDTH_OUT-1:0] nxt_trunc [LANES];
    logic [LANES-1:0]     nxt_inc;

    generate
        if (D > 0) begin : g_round
            always_comb begin
                logic [WIDTH_IN-1:0] lane;
                logic [D-1:0]        rem;
                logic [D-1:0]        half;
                logic                above;
                logic                at_half;
                logic                neg;
                round_mode_t         mode;

                mode    = round_mode_t'(s_mode);
                nxt_inc = '0;
                lane    = '0;
                rem     = '0;
                half    = '0;
                above   = 1'b0;
                at_half = 1'b0;
                neg     = 1'b0;
                for (int unsigned k = 0; k < LANES; k++) begin
                    lane    = s_data[k*WIDTH_IN +: WIDTH_IN];
                    rem     = lane[D-1:0];
                    half    = '0;
                    half[D-1] = 1'b1;
                    above   = (rem > half);
                    at_half = (rem == half);
                    neg     = SGN & lane[WIDTH_IN-1];
                    // Dropping the low bits of a two's-complement value is
                    // already floor(), so only a +1 decision is ever needed.
                    nxt_trunc[k] = lane[WIDTH_IN-1:D];
                    case (mode)
                        RND_FLOOR:     nxt_inc[k] = 1'b0;
                        RND_HALF_UP:   nxt_inc[k] = above | at_half;
                        RND_HALF_EVEN: nxt_inc[k] = above | (at_half & lane[D]);
                        RND_HALF_AWAY: nxt_inc[k] = above | (at_half & !neg);
                        default:       nxt_inc[k] = 1'b0;
                    endcase
                end
            end
        end else begin : g_pass
            // No bits are discarded, so the rounding mode has no effect.
            logic mode_unused;
            assign mode_unused = ^s_mode;

            always_comb begin
                nxt_inc = '0;
                for (int unsigned k = 0; k < LANES; k++) begin
                    nxt_trunc[k] = s_data[k*WIDTH_IN +: WIDTH_OUT];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [WIDTH_OUT-1:0] s1_trunc [LANES];
    logic [LANES-1:0]     s1_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_inc   <= '0;
            for (int unsigned k = 0; k < LANES; k++) begin
                s1_trunc[k] <= '0;
            end
        end else if (s1_load) begin
            s1_valid <= s_valid;
            if (s_valid) begin
                s1_trunc <= nxt_trunc;
                s1_inc   <= nxt_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: apply increment, then clamp
    // ------------------------------------------------------------------
    logic [LANES*WIDTH_OUT-1:0] nxt_data;
    logic [LANES-1:0]           nxt_sat;

    always_comb begin
        logic [WX-1:0]        sum;
        logic [WIDTH_OUT-1:0] clamp;

        nxt_data = '0;
        nxt_sat  = '0;
        sum      = '0;
        clamp    = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            sum = {{2{SGN & s1_trunc[k][WIDTH_OUT-1]}}, s1_trunc[k]} + WX'(s1_inc[k]);
            if (SGN) begin
                // In range only while the top three bits agree; the MSB tells
                // which rail was crossed.
                clamp = {WIDTH_OUT{~sum[WX-1]}};
                clamp[WIDTH_OUT-1] = sum[WX-1];
                if ((sum[WX-1:WX-3] != 3'b000) && (sum[WX-1:WX-3] != 3'b111)) begin
                    nxt_sat[k] = 1'b1;
                    nxt_data[k*WIDTH_OUT +: WIDTH_OUT] = clamp;
                end else begin
                    nxt_data[k*WIDTH_OUT +: WIDTH_OUT] = sum[WIDTH_OUT-1:0];
                end
            end else begin
                // Unsigned values can only overflow upward.
                if (sum[WX-1:WX-2] != 2'b00) begin
                    nxt_sat[k] = 1'b1;
                    nxt_data[k*WIDTH_OUT +: WIDTH_OUT] = '1;
                end else begin
                    nxt_data[k*WIDTH_OUT +: WIDTH_OUT] = sum[WIDTH_OUT-1:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers (these drive the outputs directly)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sat   <= '0;
        end else if (s2_load) begin
            m_valid <= s1_valid;
            if (s1_valid) begin
                m_data <= nxt_data;
                m_sat  <= nxt_sat;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturation event counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= '0;
        end else if (m_valid && m_ready && (|m_sat) && (sat_count != '1)) begin
            sat_count <= sat_count + 16'd1;
        end
    end

endmodule
